// File: rtl/video_tx_pkg.sv
// video_tx_pkg: config word layout, field codes, pipeline latencies and config unpacking for the video TX timing generator
package video_tx_pkg;

    localparam int H_TOTAL_LSB    = 0;
    localparam int H_TOTAL_W      = 12;
    localparam int H_ACTIVE_LSB   = 12;
    localparam int H_ACTIVE_W     = 11;
    localparam int H_BP_LSB       = 23;
    localparam int H_BP_W         = 9;

    localparam int H_SYNC_LSB     = 0;
    localparam int H_SYNC_W       = 9;
    localparam int V_TOTAL_LSB    = 9;
    localparam int V_TOTAL_W      = 11;
    localparam int V_ACTIVE_LSB   = 20;
    localparam int V_ACTIVE_W     = 11;
    localparam int INTERLACED_BIT = 31;

    localparam int V_BP_LSB       = 0;
    localparam int V_BP_W         = 9;
    localparam int V_SYNC_LSB     = 9;
    localparam int V_SYNC_W       = 4;
    localparam int V_LOCK_LSB     = 13;
    localparam int V_LOCK_W       = 11;
    localparam int LOCK_EN_BIT    = 24;

    localparam logic FID_ODD  = 1'b1;
    localparam logic FID_EVEN = 1'b0;

    localparam int TX_PP_LATENCY    = 3;
    localparam int TX_FETCH_LATENCY = 2;

    // All numeric fields widened to the 12-bit arithmetic width
    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_active;
        logic [11:0] h_bp;
        logic [11:0] h_sync;
        logic [11:0] v_total;
        logic [11:0] v_active;
        logic [11:0] v_bp;
        logic [11:0] v_sync;
        logic [11:0] v_lock;
        logic        interlaced;
        logic        lock_en;
    } tx_cfg_t;

    function automatic tx_cfg_t unpack_cfg(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
        tx_cfg_t c;
        c.h_total    = 12'(c1[H_TOTAL_LSB +: H_TOTAL_W]);
        c.h_active   = 12'(c1[H_ACTIVE_LSB +: H_ACTIVE_W]);
        c.h_bp       = 12'(c1[H_BP_LSB +: H_BP_W]);
        c.h_sync     = 12'(c2[H_SYNC_LSB +: H_SYNC_W]);
        c.v_total    = 12'(c2[V_TOTAL_LSB +: V_TOTAL_W]);
        c.v_active   = 12'(c2[V_ACTIVE_LSB +: V_ACTIVE_W]);
        c.interlaced = c2[INTERLACED_BIT];
        c.v_bp       = 12'(c3[V_BP_LSB +: V_BP_W]);
        c.v_sync     = 12'(c3[V_SYNC_LSB +: V_SYNC_W]);
        c.v_lock     = 12'(c3[V_LOCK_LSB +: V_LOCK_W]);
        c.lock_en    = c3[LOCK_EN_BIT];
        return c;
    endfunction

endpackage

// File: rtl/video_tx_delay.sv
// video_tx_delay: fixed-depth register delay line with a configurable reset value
module video_tx_delay #(
    parameter int           W       = 1,
    parameter int           DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [DEPTH];

    // Shift the sample one stage per clock; reset fills every stage with the idle value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/video_tx_timing_gen.sv
// video_tx_timing_gen: HSYNC/VSYNC/DE/FID and fetch-coordinate generator with aligned RGB return; VIDEO_TX_FRAMELOCK_EN adds VSYNC framelock
module video_tx_timing_gen
    import video_tx_pkg::*;
(
    input  logic        PCLK_i,
    input  logic        reset_i,
    input  logic [31:0] hv_out_config,
    input  logic [31:0] hv_out_config2,
    input  logic [31:0] hv_out_config3,
    input  logic        vsync_ref_i,
    input  logic [7:0]  R_i,
    input  logic [7:0]  G_i,
    input  logic [7:0]  B_i,
    output logic        req_de_o,
    output logic [10:0] req_xpos_o,
    output logic [10:0] req_ypos_o,
    output logic [7:0]  R_o,
    output logic [7:0]  G_o,
    output logic [7:0]  B_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        DE_o,
    output logic        FID_o,
    output logic        frame_start_o
);

    tx_cfg_t     cfg_q, cfg;
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        odd_q, odd_d, lock_q, lock, load, h_wrap, v_wrap;
    logic [11:0] fl_odd, fl, half, hstart, vstart, lock_line;
    logic        hs0, vs_low0, de0, fs0, de_s2_q;
    logic [10:0] x0, y0;
    logic        unused_bits;

    assign unused_bits = ^hv_out_config3[31:25];

`ifdef VIDEO_TX_FRAMELOCK_EN
    logic vref_q;

    // Previous reference VSYNC level for falling-edge detection
    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) vref_q <= 1'b0;
        else         vref_q <= vsync_ref_i;
    end

    assign lock      = cfg.lock_en && vref_q && !vsync_ref_i;
    assign lock_line = (cfg.v_lock >= fl_odd) ? 12'd0 : cfg.v_lock;
`else
    logic unused_lock;

    assign unused_lock = ^{vsync_ref_i, cfg.v_lock, cfg.lock_en};
    assign lock        = 1'b0;
    assign lock_line   = 12'd0;
`endif

    // Stage 0: shadow selection, counter next-state and raw sync/DE/coordinate decode
    always_comb begin
        fs0      = h_cnt_q == 12'd0 && v_cnt_q == 12'd0 && odd_q == FID_ODD;
        load     = fs0 && !lock_q;
        cfg      = load ? unpack_cfg(hv_out_config, hv_out_config2, hv_out_config3) : cfg_q;
        fl_odd   = cfg.interlaced ? (cfg.v_total + 12'd1) >> 1 : cfg.v_total;
        fl       = (!cfg.interlaced || odd_q == FID_ODD) ? fl_odd : cfg.v_total >> 1;
        h_wrap   = h_cnt_q >= cfg.h_total - 12'd1;
        v_wrap   = v_cnt_q >= fl - 12'd1;
        h_cnt_d  = (lock || h_wrap) ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d  = lock ? lock_line : !h_wrap ? v_cnt_q : v_wrap ? 12'd0 : v_cnt_q + 12'd1;
        odd_d    = lock ? FID_ODD : !(h_wrap && v_wrap) ? odd_q : cfg.interlaced ? ~odd_q : FID_ODD;
        half     = cfg.h_total >> 1;
        hstart   = cfg.h_sync + cfg.h_bp;
        vstart   = cfg.v_sync + cfg.v_bp;
        hs0      = !(h_cnt_q < cfg.h_sync);
        vs_low0  = (odd_q == FID_ODD) ? v_cnt_q < cfg.v_sync :
                   (v_cnt_q != 12'd0 || h_cnt_q >= half) &&
                   (v_cnt_q < cfg.v_sync || (v_cnt_q == cfg.v_sync && h_cnt_q < half));
        de0      = h_cnt_q >= hstart && h_cnt_q < hstart + cfg.h_active &&
                   v_cnt_q >= vstart && v_cnt_q < vstart + cfg.v_active;
        x0       = h_cnt_q[10:0] - hstart[10:0];
        y0       = v_cnt_q[10:0] - vstart[10:0];
    end

    // Counters, shadow config, fetch request (stage 1) and RGB capture (stage 3)
    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            odd_q      <= FID_ODD;
            cfg_q      <= '0;
            lock_q     <= 1'b0;
            req_de_o   <= 1'b0;
            req_xpos_o <= '0;
            req_ypos_o <= '0;
            de_s2_q    <= 1'b0;
            R_o        <= '0;
            G_o        <= '0;
            B_o        <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            odd_q      <= odd_d;
            cfg_q      <= cfg;
            lock_q     <= lock;
            req_de_o   <= de0;
            req_xpos_o <= x0;
            req_ypos_o <= y0;
            de_s2_q    <= req_de_o;
            R_o        <= de_s2_q ? R_i : 8'd0;
            G_o        <= de_s2_q ? G_i : 8'd0;
            B_o        <= de_s2_q ? B_i : 8'd0;
        end
    end

    video_tx_delay #(
        .W      (5),
        .DEPTH  (TX_PP_LATENCY),
        .RST_VAL(5'b11010)
    ) u_ctl_delay (
        .clk_i (PCLK_i),
        .rst_i (reset_i),
        .d_i   ({hs0, ~vs_low0, de0, odd_q, fs0}),
        .q_o   ({HSYNC_o, VSYNC_o, DE_o, FID_o, frame_start_o})
    );

endmodule

// File: tb/tb_video_tx_timing_gen.sv
// tb_video_tx_timing_gen: table-driven frame statistics plus directed reset, interlace, config-change and framelock sequences
module tb_video_tx_timing_gen;

`ifdef VIDEO_TX_FRAMELOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        PCLK_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] hv_out_config = '0, hv_out_config2 = '0, hv_out_config3 = '0;
    logic        vsync_ref_i = 1'b1;
    logic [7:0]  R_i, G_i, B_i;
    logic        req_de_o;
    logic [10:0] req_xpos_o, req_ypos_o;
    logic [7:0]  R_o, G_o, B_o;
    logic        HSYNC_o, VSYNC_o, DE_o, FID_o, frame_start_o;

    int checks = 0;
    int errors = 0;

    video_tx_timing_gen dut (
        .PCLK_i        (PCLK_i),
        .reset_i       (reset_i),
        .hv_out_config (hv_out_config),
        .hv_out_config2(hv_out_config2),
        .hv_out_config3(hv_out_config3),
        .vsync_ref_i   (vsync_ref_i),
        .R_i           (R_i),
        .G_i           (G_i),
        .B_i           (B_i),
        .req_de_o      (req_de_o),
        .req_xpos_o    (req_xpos_o),
        .req_ypos_o    (req_ypos_o),
        .R_o           (R_o),
        .G_o           (G_o),
        .B_o           (B_o),
        .HSYNC_o       (HSYNC_o),
        .VSYNC_o       (VSYNC_o),
        .DE_o          (DE_o),
        .FID_o         (FID_o),
        .frame_start_o (frame_start_o)
    );

    always #5 PCLK_i = ~PCLK_i;

    // Line-buffer model: data for a request is presented two cycles after the counter cycle that issued it
    logic [7:0] mem_x, mem_y;
    always @(posedge PCLK_i) begin
        mem_x <= req_xpos_o[7:0];
        mem_y <= req_ypos_o[7:0];
    end
    assign R_i = mem_x;
    assign G_i = ~mem_x;
    assign B_i = mem_y;

    typedef struct {
        logic [31:0] c1, c2, c3;
        int hs_low, vs_low, de_hi, period, fid_hi;
    } vec_t;

    vec_t vecs [3];

    function automatic logic [31:0] mk1(input int ht, input int ha, input int hbp);
        return {9'(hbp), 11'(ha), 12'(ht)};
    endfunction
    function automatic logic [31:0] mk2(input int hs, input int vt, input int va, input int il);
        return {1'(il), 11'(va), 11'(vt), 9'(hs)};
    endfunction
    function automatic logic [31:0] mk3(input int vbp, input int vs, input int vl, input int le);
        return {7'd0, 1'(le), 11'(vl), 4'(vs), 9'(vbp)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_ctl"}, int'({HSYNC_o, VSYNC_o, DE_o, FID_o, frame_start_o, req_de_o}), 6'b110100);
        chk({nm, "_data"}, int'(R_o | G_o | B_o) + int'(req_xpos_o | req_ypos_o), 0);
    endtask

    task automatic do_reset(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
        @(negedge PCLK_i);
        reset_i = 1'b1;
        hv_out_config = c1;
        hv_out_config2 = c2;
        hv_out_config3 = c3;
        vsync_ref_i = 1'b1;
        repeat (3) @(negedge PCLK_i);
        chk_rst("reset");
        reset_i = 1'b0;
    endtask

    task automatic first_pulse(input string nm);
        logic [3:0] fs_pat;
        logic [3:0] de_pat;
        fs_pat = '0;
        de_pat = '0;
        for (int j = 0; j < 4; j++) begin
            @(negedge PCLK_i);
            fs_pat = {fs_pat[2:0], frame_start_o};
            de_pat = {de_pat[2:0], DE_o};
        end
        chk({nm, "_fs"}, int'(fs_pat), 4'b0010);
        chk({nm, "_de"}, int'(de_pat), 0);
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (!frame_start_o && n < 5000) begin
            @(negedge PCLK_i);
            n++;
        end
        if (!frame_start_o) chk("frame_start_timeout", 0, 1);
    endtask

    task automatic wait_req(input int x, input int y);
        int n;
        n = 0;
        while (!(req_xpos_o == 11'(x) && req_ypos_o == 11'(y)) && n < 5000) begin
            @(negedge PCLK_i);
            n++;
        end
        if (n >= 5000) chk("req_timeout", 0, 1);
    endtask

    task automatic measure(input int chg_at, input logic [31:0] chg_c1,
                           output int hs, output int vs, output int de, output int per,
                           output int fid, output int rgb_err);
        int x;
        hs = 0; vs = 0; de = 0; per = 0; fid = 0; rgb_err = 0; x = 0;
        wait_fs();
        do begin
            if (!HSYNC_o) hs++;
            if (!VSYNC_o) vs++;
            if (FID_o) fid++;
            if (DE_o) begin
                de++;
                if (R_o != 8'(x) || G_o != 8'(~x)) rgb_err++;
                x++;
            end else begin
                x = 0;
                if ((R_o | G_o | B_o) != 8'd0) rgb_err++;
            end
            per++;
            if (per == chg_at) hv_out_config = chg_c1;
            @(negedge PCLK_i);
        end while (!frame_start_o && per < 5000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hs, vs, de, per, fid, rgb_err, k, m, e, fsn;
        logic [1:0] hpat;
        vecs[0] = '{mk1(20, 8, 3),  mk2(4, 12, 6, 0), mk3(2, 2, 0, 0), 48, 40, 48, 240, 240};
        vecs[1] = '{mk1(16, 10, 1), mk2(2, 8, 5, 0),  mk3(1, 1, 0, 0), 16, 16, 50, 128, 128};
        vecs[2] = '{mk1(22, 12, 2), mk2(3, 13, 3, 1), mk3(1, 2, 0, 0), 39, 88, 72, 286, 154};

        for (int i = 0; i < 3; i++) begin
            do_reset(vecs[i].c1, vecs[i].c2, vecs[i].c3);
            first_pulse("first");
            measure(0, '0, hs, vs, de, per, fid, rgb_err);
            chk("hsync_low", hs, vecs[i].hs_low);
            chk("vsync_low", vs, vecs[i].vs_low);
            chk("de_high", de, vecs[i].de_hi);
            chk("frame_period", per, vecs[i].period);
            chk("fid_high", fid, vecs[i].fid_hi);
            chk("rgb_align", rgb_err, 0);
            if (i == 2) begin
                k = 0;
                while (FID_o && k < 1000) begin @(negedge PCLK_i); k++; end
                k = 0;
                while (VSYNC_o && k < 1000) begin @(negedge PCLK_i); k++; end
                chk("even_vs_fall_h", k, 11);
                m = 0;
                while (!VSYNC_o && m < 1000) begin @(negedge PCLK_i); m++; end
                chk("even_vs_len", m, 44);
                e = k + m;
                while (!FID_o && e < 1000) begin @(negedge PCLK_i); e++; end
                chk("even_field_len", e, 132);
            end
        end

        do_reset(vecs[0].c1, vecs[0].c2, vecs[0].c3);
        measure(50, mk1(20, 4, 3), hs, vs, de, per, fid, rgb_err);
        chk("cfg_chg_cur_de", de, 48);
        measure(0, '0, hs, vs, de, per, fid, rgb_err);
        chk("cfg_chg_next_de", de, 24);
        chk("cfg_chg_rgb", rgb_err, 0);

        k = 0;
        while (!DE_o && k < 1000) begin @(negedge PCLK_i); k++; end
        chk("pre_reset_de", int'(DE_o), 1);
        #2 reset_i = 1'b1;
        #1 chk_rst("async_reset");
        e = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge PCLK_i);
            if ({HSYNC_o, VSYNC_o, DE_o, FID_o, frame_start_o, req_de_o} != 6'b110100 ||
                (R_o | G_o | B_o) != 8'd0) e++;
        end
        chk("reset_hold", e, 0);
        reset_i = 1'b0;
        first_pulse("release");

        do_reset(vecs[0].c1, vecs[0].c2, mk3(2, 2, 10, 1));
        wait_req(2046, 2);
        vsync_ref_i = 1'b0;
        repeat (2) @(negedge PCLK_i);
        chk("lock_req_x", int'(req_xpos_o), LOCK ? 2041 : 0);
        chk("lock_req_y", int'(req_ypos_o), LOCK ? 6 : 2);
        @(negedge PCLK_i);
        hpat[1] = HSYNC_o;
        @(negedge PCLK_i);
        hpat[0] = HSYNC_o;
        chk("lock_hsync", int'(hpat), LOCK ? 2'b10 : 2'b11);
        vsync_ref_i = 1'b1;
        repeat (3) @(negedge PCLK_i);
        wait_req(11, 7);
        vsync_ref_i = 1'b0;
        repeat (2) @(negedge PCLK_i);
        chk("lock_wrap_y", int'(req_ypos_o), LOCK ? 6 : 2044);
        chk("lock_wrap_x", int'(req_xpos_o), 2041);
        fsn = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge PCLK_i);
            if (frame_start_o) fsn++;
        end
        chk("lock_wrap_fs", fsn, LOCK ? 0 : 1);
        vsync_ref_i = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
